tdm_demux4: RTL and testbench

Receive-side partner of the 4:1 select multiplexer. It takes the time-multiplexed stream produced by cycling the select code 00→01→10→11 and reconstructs the four parallel lanes. It tracks the slot index with a frame-synchronised counter and collects samples in a shadow register. Each complete frame is presented atomically on `b` with a one-cycle valid pulse. It sits between a TDM link and arithmetic blocks that consume 4-lane words.

---
 rtl/tdm_demux4_if.sv | 37 +++
 rtl/tdm_demux4.sv | 128 ++++++++++++
 tb/tb_tdm_demux4.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux4_if.sv
// Bus bundle between a TDM sender and the tdm_demux4 receiver.
// The sender (master) drives the sample stream; the receiver (slave)
// returns the reconstructed 4-lane word, the slot index and error status.
interface tdm_demux4_if #(
    parameter int W = 1
);
    logic [W-1:0]   din;
    logic           din_valid;
    logic           frame_start;
    logic [4*W-1:0] b;
    logic [1:0]     s;
    logic           word_valid;
    logic           sync_err;
    logic [7:0]     err_cnt;

    modport master (
        output din,
        output din_valid,
        output frame_start,
        input  b,
        input  s,
        input  word_valid,
        input  sync_err,
        input  err_cnt
    );

    modport slave (
        input  din,
        input  din_valid,
        input  frame_start,
        output b,
        output s,
        output word_valid,
        output sync_err,
        output err_cnt
    );
endinterface

// File: rtl/tdm_demux4.sv
// tdm_demux4: receive side of a 4-slot TDM link.
// Samples are gathered slot by slot into a shadow register. The whole
// word is published on b in one step when slot 3 arrives, so a
// downstream consumer never sees a partially filled frame.
module tdm_demux4 #(
    parameter int W = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    tdm_demux4_if.slave   bus
);

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     s_q, s_d;
    logic [4*W-1:0] b_q, b_d;
    logic           word_valid_q, word_valid_d;
    logic           sync_err_q, sync_err_d;
    logic [7:0]     err_cnt_q, err_cnt_d;

    // Only lanes 0..2 need shadowing: lane 3 goes straight from din into b.
    logic [W-1:0]   shadow_q [3];
    logic [W-1:0]   shadow_d [3];

    // restart: current sample opens a new frame as lane 0 (clears lanes 1..2).
    // store:   current sample fills lane s_q (s_q is 1 or 2 here, or 0 unmarked).
    logic           restart;
    logic           store;

    // Next-state and control decode for the alignment FSM.
    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        b_d          = b_q;
        word_valid_d = 1'b0;
        sync_err_d   = 1'b0;
        err_cnt_d    = err_cnt_q;
        restart      = 1'b0;
        store        = 1'b0;

        if (bus.din_valid) begin
            case (state_q)
                HUNT: begin
                    // Unmarked samples are dropped until a frame marker shows up.
                    if (bus.frame_start) begin
                        restart = 1'b1;
                        state_d = COLLECT;
                        s_d     = 2'd1;
                    end
                end
                COLLECT: begin
                    if (bus.frame_start && (s_q != 2'd0)) begin
                        // Marker in the middle of a frame: drop the partial
                        // frame and realign on this sample.
                        restart    = 1'b1;
                        s_d        = 2'd1;
                        sync_err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end else if (s_q == 2'd3) begin
                        // Frame complete: publish all four lanes at once.
                        b_d          = {shadow_q[0], shadow_q[1], shadow_q[2], bus.din};
                        word_valid_d = 1'b1;
                        s_d          = 2'd0;
                    end else begin
                        // Slot 0 is accepted with or without a marker.
                        store = 1'b1;
                        s_d   = s_q + 2'd1;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // Per-lane shadow next value: lane 0 takes the sample on a restart,
    // the other lanes are cleared; otherwise only the addressed lane loads.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : gen_lane
            localparam logic [1:0] LANE = 2'(gi);
            if (gi == 0) begin : gen_first
                assign shadow_d[gi] = (restart || (store && (s_q == LANE)))
                                      ? bus.din : shadow_q[gi];
            end else begin : gen_rest
                assign shadow_d[gi] = restart                    ? '0 :
                                      (store && (s_q == LANE))   ? bus.din :
                                                                   shadow_q[gi];
            end
        end
    endgenerate

    // State, output and shadow registers; reset wins over any input event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            s_q          <= 2'd0;
            b_q          <= '0;
            word_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
            err_cnt_q    <= 8'd0;
            for (int i = 0; i < 3; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            b_q          <= b_d;
            word_valid_q <= word_valid_d;
            sync_err_q   <= sync_err_d;
            err_cnt_q    <= err_cnt_d;
            shadow_q     <= shadow_d;
        end
    end

    assign bus.b          = b_q;
    assign bus.s          = s_q;
    assign bus.word_valid = word_valid_q;
    assign bus.sync_err   = sync_err_q;
    assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed frames followed by random
// traffic; a frame-level reference model predicts events into a scoreboard.
module tb_tdm_demux4;
    localparam int W = 1;

    typedef struct {
        bit             is_err;
        logic [4*W-1:0] b;
        logic [7:0]     cnt;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tdm_demux4_if #(.W(W)) bus ();

    tdm_demux4 #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: aligned flag plus the list of samples of the open frame.
    bit             m_aligned;
    logic [W-1:0]   m_frame[$];
    logic [4*W-1:0] m_b;
    logic [7:0]     m_err;
    ev_t            exp_q[$];
    bit             mon_en = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(bit r_n, bit v, bit fs, logic [W-1:0] d);
        ev_t ev;
        if (!r_n) begin
            m_aligned = 1'b0;
            m_frame.delete();
            m_b   = '0;
            m_err = 8'd0;
        end else if (v) begin
            if (!m_aligned) begin
                if (fs) begin
                    m_aligned = 1'b1;
                    m_frame.delete();
                    m_frame.push_back(d);
                end
            end else if (fs && m_frame.size() != 0) begin
                if (m_err != 8'd255) m_err = m_err + 8'd1;
                m_frame.delete();
                m_frame.push_back(d);
                ev.is_err = 1'b1;
                ev.b      = m_b;
                ev.cnt    = m_err;
                exp_q.push_back(ev);
            end else begin
                m_frame.push_back(d);
                if (m_frame.size() == 4) begin
                    m_b = {m_frame[0], m_frame[1], m_frame[2], m_frame[3]};
                    m_frame.delete();
                    ev.is_err = 1'b0;
                    ev.b      = m_b;
                    ev.cnt    = m_err;
                    exp_q.push_back(ev);
                end
            end
        end
    endtask

    // One clock cycle of stimulus; the model advances right after the edge.
    task automatic cyc(bit v, bit fs, logic [W-1:0] d);
        bus.din_valid   = v;
        bus.frame_start = fs;
        bus.din         = d;
        @(posedge clk);
        #1;
        model_step(rst_n, v, fs, d);
    endtask

    task automatic frame4(logic [3:0] bits, bit mark, int gap);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, mark && (i == 0), bits[3-i]);
            for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, '0);
        end
    endtask

    // Monitor: per-cycle state checks and scoreboard pop on each output pulse.
    always @(negedge clk) begin
        ev_t ev;
        if (mon_en) begin
            check("s", 32'(bus.s), 32'(m_frame.size()));
            check("b_hold", 32'(bus.b), 32'(m_b));
            check("err_cnt", 32'(bus.err_cnt), 32'(m_err));
            check("pulse_excl", 32'(bus.word_valid & bus.sync_err), 32'd0);
            if (bus.word_valid || bus.sync_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, bus.word_valid, bus.sync_err}, 32'd0);
                end else begin
                    ev = exp_q.pop_front();
                    check("ev_kind", 32'(bus.sync_err), 32'(ev.is_err));
                    check("ev_b", 32'(bus.b), 32'(ev.b));
                    check("ev_cnt", 32'(bus.err_cnt), 32'(ev.cnt));
                    $display("%0t: %s b=%h err_cnt=%0d", $time,
                             ev.is_err ? "sync_err" : "word", bus.b, bus.err_cnt);
                end
            end
            if (exp_q.size() != 0) begin
                check("missed_pulse", 32'(exp_q.size()), 32'd0);
                exp_q.delete();
            end
        end
    end

    initial begin
        bus.din_valid   = 1'b0;
        bus.frame_start = 1'b0;
        bus.din         = '0;
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Idle after reset.
        repeat (3) cyc(1'b0, 1'b0, '0);
        check("rst_b", 32'(bus.b), 32'd0);
        check("rst_wv", 32'(bus.word_valid), 32'd0);

        // Single framed word.
        frame4(4'b0101, 1'b1, 0);
        check("tp_0101", 32'(bus.b), 32'h5);
        check("tp_0101_wv", 32'(bus.word_valid), 32'd1);

        // Back-to-back, only the first frame marked.
        frame4(4'b1100, 1'b1, 0);
        check("tp_1100", 32'(bus.b), 32'hC);
        frame4(4'b0011, 1'b0, 0);
        check("tp_0011", 32'(bus.b), 32'h3);

        // Unmarked samples in HUNT are ignored.
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, '0);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        check("hunt_s", 32'(bus.s), 32'd0);
        frame4(4'b1001, 1'b1, 0);
        check("tp_1001", 32'(bus.b), 32'h9);

        // Frame cut short by a marker.
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        check("cut_err", 32'(bus.sync_err), 32'd1);
        check("cut_cnt", 32'(bus.err_cnt), 32'd1);
        check("cut_bkeep", 32'(bus.b), 32'h9);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        check("tp_0111", 32'(bus.b), 32'h7);

        // Reset mid-frame (with a marked sample present), then a gapped frame.
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        cyc(1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
        check("midrst_b", 32'(bus.b), 32'd0);
        check("midrst_cnt", 32'(bus.err_cnt), 32'd0);
        frame4(4'b1010, 1'b1, 2);
        check("tp_1010", 32'(bus.b), 32'hA);

        // Error counter saturation.
        cyc(1'b1, 1'b1, 1'b0);
        repeat (260) cyc(1'b1, 1'b1, 1'b1);
        check("sat_cnt", 32'(bus.err_cnt), 32'd255);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, W'($urandom));
        end
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, '0);
        @(negedge clk);
        #1;
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
